// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO port: register offsets, AHB encodings,
// and the byte-lane decode used by the register file.
package gpio_pkg;

   typedef enum logic [2:0] {
      OFF_DATA_OUT = 3'd0,
      OFF_DIR      = 3'd1,
      OFF_DATA_IN  = 3'd2,
      OFF_IM       = 3'd3,
      OFF_EDGE     = 3'd4,
      OFF_IS       = 3'd5,
      OFF_RSVD6    = 3'd6,
      OFF_RSVD7    = 3'd7
   } reg_off_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Larger sizes are treated as a full word.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << lo;
         HSIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchronizer with per-pin rising/falling edge detection,
// held quiet until the synchronizer and history flop carry real pin state.
module gpio_sync_edge import gpio_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [WIDTH-1:0] GPIO_IN,
   input  logic [WIDTH-1:0] EDGE,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] edge_det
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] prev_q;
   logic [1:0]       warm_q;
   logic             armed_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   // armed_q trails the saturated counter by one cycle so the first compare
   // already sees prev_q loaded from a valid sync2_q.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         warm_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= GPIO_IN;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
         armed_q <= (warm_q == 2'd2);
      end
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   always_comb begin
      edge_det = '0;
      if (armed_q) edge_det = (EDGE & fall) | (~EDGE & rise);
   end

   assign sync = sync2_q;

endmodule

// File: rtl/ahbl_gpio_port.sv
// AHB-Lite zero-wait-state GPIO bank: output/direction registers, synchronized
// input readback and sticky edge interrupt status with a masked level IRQ.
module ahbl_gpio_port import gpio_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic [2:0]       HSIZE,
   input  logic [31:0]      HWDATA,
   input  logic             HREADY,
   output logic             HREADYOUT,
   output logic             HRESP,
   output logic [31:0]      HRDATA,
   output logic [WIDTH-1:0] GPIO_OUT,
   output logic [WIDTH-1:0] GPIO_OE,
   input  logic [WIDTH-1:0] GPIO_IN,
   output logic             IRQ
);

   logic             accept;
   logic             pend_q;
   logic             pend_write_q;
   reg_off_e         pend_off_q;
   logic [2:0]       pend_size_q;
   logic [1:0]       pend_lo_q;

   logic [WIDTH-1:0] data_out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] im_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] is_q;

   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] edge_det;
   logic [3:0]       lanes;
   logic [31:0]      bmask;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rd_val;
   logic             unused_ok;

   assign accept    = HSEL & HTRANS[1] & HREADY;
   assign unused_ok = ^{HADDR[31:5], HTRANS[0]};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         pend_q       <= 1'b0;
         pend_write_q <= 1'b0;
         pend_off_q   <= OFF_DATA_OUT;
         pend_size_q  <= '0;
         pend_lo_q    <= '0;
      end else if (accept) begin
         pend_q       <= 1'b1;
         pend_write_q <= HWRITE;
         pend_off_q   <= reg_off_e'(HADDR[4:2]);
         pend_size_q  <= HSIZE;
         pend_lo_q    <= HADDR[1:0];
      end else begin
         pend_q       <= 1'b0;
      end
   end

   gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .GPIO_IN  (GPIO_IN),
      .EDGE     (edge_q),
      .sync     (data_in),
      .edge_det (edge_det)
   );

   assign lanes = lane_mask(pend_size_q, pend_lo_q);
   assign bmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
   assign wmask = bmask[WIDTH-1:0];
   assign wdata = HWDATA[WIDTH-1:0];
   assign wr_en = pend_q & pend_write_q;
   assign w1c   = (wr_en && pend_off_q == OFF_IS) ? (wdata & wmask) : '0;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         data_out_q <= '0;
         dir_q      <= '0;
         im_q       <= '0;
         edge_q     <= '0;
         is_q       <= '0;
      end else begin
         if (wr_en) begin
            case (pend_off_q)
               OFF_DATA_OUT: data_out_q <= (data_out_q & ~wmask) | (wdata & wmask);
               OFF_DIR:      dir_q      <= (dir_q & ~wmask) | (wdata & wmask);
               OFF_IM:       im_q       <= (im_q & ~wmask) | (wdata & wmask);
               OFF_EDGE:     edge_q     <= (edge_q & ~wmask) | (wdata & wmask);
               default:      ;
            endcase
         end
         // A new edge in the same cycle as its write-1-to-clear keeps the bit set.
         is_q <= (is_q & ~w1c) | edge_det;
      end
   end

   always_comb begin
      rd_val = '0;
      case (pend_off_q)
         OFF_DATA_OUT: rd_val = data_out_q;
         OFF_DIR:      rd_val = dir_q;
         OFF_DATA_IN:  rd_val = data_in;
         OFF_IM:       rd_val = im_q;
         OFF_EDGE:     rd_val = edge_q;
         OFF_IS:       rd_val = is_q;
         OFF_RSVD6:    rd_val = '0;
         OFF_RSVD7:    rd_val = '0;
         default:      rd_val = '0;
      endcase
   end

   always_comb begin
      HRDATA = '0;
      if (pend_q && !pend_write_q) HRDATA[WIDTH-1:0] = rd_val;
   end

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign GPIO_OUT  = data_out_q;
   assign GPIO_OE   = dir_q;
   assign IRQ       = |(is_q & im_q);

endmodule

// File: tb/tb_ahbl_gpio_port.sv
// Self-checking bench for ahbl_gpio_port: bus reads are checked against a queue
// of expected values, pin/IRQ timing is checked cycle by cycle.
module tb_ahbl_gpio_port;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [31:0] GPIO_OUT;
   logic [31:0] GPIO_OE;
   logic [31:0] GPIO_IN;
   logic        IRQ;
   logic [31:0] ext_in;

   int checks = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] expv;

   localparam logic [31:0] A_DATA_OUT = 32'h00;
   localparam logic [31:0] A_DIR      = 32'h04;
   localparam logic [31:0] A_DATA_IN  = 32'h08;
   localparam logic [31:0] A_IM       = 32'h0C;
   localparam logic [31:0] A_EDGE     = 32'h10;
   localparam logic [31:0] A_IS       = 32'h14;

   // Pads: driven pins loop back, undriven pins follow the external source.
   assign GPIO_IN = (GPIO_OE & GPIO_OUT) | (~GPIO_OE & ext_in);

   always #5 HCLK = ~HCLK;

   ahbl_gpio_port #(.WIDTH(32)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .GPIO_OUT  (GPIO_OUT),
      .GPIO_OE   (GPIO_OE),
      .GPIO_IN   (GPIO_IN),
      .IRQ       (IRQ)
   );

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
      @(negedge HCLK);
      rdata  = HRDATA;
      HSEL   = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      HWDATA = wdata;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      xfer(1'b1, addr, 3'd2, data, d);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      xfer(1'b0, addr, 3'd2, 32'h0, data);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic test_reset;
      HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'd2; HWDATA = '0; HREADY = 1'b1; ext_in = '1;
      idle(3);
      checks++;
      if ({GPIO_OUT, GPIO_OE, IRQ, HRDATA} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL reset_outputs: got out=%h oe=%h irq=%b rdata=%h, expected all 0",
                  GPIO_OUT, GPIO_OE, IRQ, HRDATA);
      end
      checks++;
      if ({HREADYOUT, HRESP} !== 2'b10) begin
         fails++;
         $display("FAIL reset_resp: got readyout=%b resp=%b, expected 1 0", HREADYOUT, HRESP);
      end
      HRESET = 1'b0;
      idle(6);
      wr(A_IM, 32'hFFFF_FFFF);
      idle(2);
      exp_q.push_back(32'h0);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL warmup_is: got %h expected %h", got, expv); end
      checks++;
      if (IRQ !== 1'b0) begin fails++; $display("FAIL warmup_irq: got %b expected 0", IRQ); end
      exp_q.push_back(32'hFFFF_FFFF);
      rd(A_DATA_IN, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL data_in_high: got %h expected %h", got, expv); end
      wr(A_IM, 32'h0);
   endtask

   task automatic test_loopback;
      ext_in = '0;
      idle(5);
      wr(A_IS, 32'hFFFF_FFFF);
      wr(A_DIR, 32'h0000_00FF);
      checks++;
      if (GPIO_OE !== 32'h0) begin fails++; $display("FAIL oe_early: got %h expected 0", GPIO_OE); end
      @(posedge HCLK); #1;
      checks++;
      if (GPIO_OE !== 32'hFF) begin fails++; $display("FAIL oe_set: got %h expected 000000ff", GPIO_OE); end
      wr(A_DATA_OUT, 32'h0000_00A5);
      @(posedge HCLK); #1;
      checks++;
      if (GPIO_OUT !== 32'hA5) begin fails++; $display("FAIL out_set: got %h expected 000000a5", GPIO_OUT); end
      idle(4);
      exp_q.push_back(32'h0000_00A5);
      rd(A_DATA_IN, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL loopback_in: got %h expected %h", got, expv); end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] d;
      wr(A_DATA_OUT, 32'h1122_3344);
      xfer(1'b1, 32'h01, 3'd0, 32'hFFFF_3CFF, d);
      exp_q.push_back(32'h1122_3C44);
      rd(A_DATA_OUT, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL byte_write: got %h expected %h", got, expv); end
      xfer(1'b1, 32'h02, 3'd1, 32'hBEEF_0000, d);
      exp_q.push_back(32'hBEEF_3C44);
      rd(A_DATA_OUT, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL half_write: got %h expected %h", got, expv); end
      exp_q.push_back(32'h0000_00FF);
      rd(A_DIR, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL dir_untouched: got %h expected %h", got, expv); end
   endtask

   task automatic test_irq_rise;
      logic [31:0] d;
      logic [2:0]  irq_seen;
      wr(A_DIR, 32'h0);
      idle(5);
      wr(A_IS, 32'hFFFF_FFFF);
      wr(A_EDGE, 32'h0);
      wr(A_IM, 32'h1);
      exp_q.push_back(32'h0);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL is_clear: got %h expected %h", got, expv); end
      @(negedge HCLK);
      ext_in[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge HCLK); #1;
         irq_seen[i] = IRQ;
      end
      checks++;
      if (irq_seen !== 3'b100) begin
         fails++;
         $display("FAIL irq_latency: got e2..e0=%b expected 100", irq_seen);
      end
      exp_q.push_back(32'h1);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL is_rise: got %h expected %h", got, expv); end
      xfer(1'b1, A_IS, 3'd2, 32'h1, d);
      checks++;
      if (IRQ !== 1'b1) begin fails++; $display("FAIL irq_hold: got %b expected 1", IRQ); end
      @(posedge HCLK); #1;
      checks++;
      if (IRQ !== 1'b0) begin fails++; $display("FAIL irq_w1c: got %b expected 0", IRQ); end
   endtask

   task automatic test_falling_edge;
      logic [31:0] d;
      wr(A_EDGE, 32'h8);
      @(negedge HCLK); ext_in[3] = 1'b1;
      idle(5);
      exp_q.push_back(32'h0);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL fall_ignores_rise: got %h expected %h", got, expv); end
      @(negedge HCLK); ext_in[3] = 1'b0;
      idle(5);
      exp_q.push_back(32'h8);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL fall_sets: got %h expected %h", got, expv); end
      @(negedge HCLK); ext_in[3] = 1'b1;
      idle(5);
      // Fall lands before e0 so the status set coincides with the W1C data phase.
      @(negedge HCLK); ext_in[3] = 1'b0;
      xfer(1'b1, A_IS, 3'd2, 32'h8, d);
      idle(2);
      exp_q.push_back(32'h8);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL set_beats_w1c: got %h expected %h", got, expv); end
      wr(A_IS, 32'h8);
      exp_q.push_back(32'h0);
      rd(A_IS, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL w1c_clears: got %h expected %h", got, expv); end
   endtask

   task automatic test_back_to_back;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_IM; HSIZE = 3'd2;
      @(negedge HCLK);
      HWDATA = 32'hF; HWRITE = 1'b0; HADDR = A_IM;
      exp_q.push_back(32'h0000_000F);
      @(negedge HCLK);
      got = HRDATA;
      HSEL = 1'b0; HTRANS = 2'b00;
      expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL b2b_read: got %h expected %h", got, expv); end
      exp_q.push_back(32'h0);
      rd(32'h1C, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
         fails++;
         $display("FAIL rsvd_1c: got %h resp=%b ready=%b expected %h resp=0 ready=1",
                  got, HRESP, HREADYOUT, expv);
      end
      wr(32'h18, 32'hDEAD_BEEF);
      exp_q.push_back(32'h0);
      rd(32'h18, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL rsvd_18: got %h expected %h", got, expv); end
   endtask

   task automatic test_reset_mid_transfer;
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_DATA_OUT; HSIZE = 3'd2;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h5A; HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      checks++;
      if (GPIO_OUT !== 32'h0) begin fails++; $display("FAIL reset_abort: got %h expected 0", GPIO_OUT); end
      exp_q.push_back(32'h0);
      rd(A_DATA_OUT, got); expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin fails++; $display("FAIL reset_abort_rd: got %h expected %h", got, expv); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_loopback;
      test_byte_lanes;
      test_irq_rise;
      test_falling_edge;
      test_back_to_back;
      test_reset_mid_transfer;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
